// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: opcodes, flag bit positions, FSM encoding and condition decode.
package branch_pkg;

  localparam logic [5:0] OP_BR  = 6'b001110;
  localparam logic [5:0] OP_BMI = 6'b001111;
  localparam logic [5:0] OP_BPL = 6'b010000;
  localparam logic [5:0] OP_BZ  = 6'b010001;
  localparam logic [5:0] OP_BNZ = 6'b010010;
  localparam logic [5:0] OP_BC  = 6'b010011;
  localparam logic [5:0] OP_BNC = 6'b010100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic is_br;
    logic uncond;
    logic taken;
  } br_dec_t;

  // f is {C,S,Z}; non-branch opcodes come back with is_br=0 and are ignored upstream
  function automatic br_dec_t decode_br(input logic [5:0] op, input logic [2:0] f);
    br_dec_t d;
    d = '0;
    d.is_br = 1'b1;
    case (op)
      OP_BR:   begin d.uncond = 1'b1; d.taken = 1'b1; end
      OP_BMI:  d.taken = f[FLAG_S];
      OP_BPL:  d.taken = ~f[FLAG_S] & ~f[FLAG_Z];
      OP_BZ:   d.taken = f[FLAG_Z];
      OP_BNZ:  d.taken = ~f[FLAG_Z];
      OP_BC:   d.taken = f[FLAG_C];
      OP_BNC:  d.taken = ~f[FLAG_C];
      default: d.is_br = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating direction counters: combinational read port, one update port.
module bp_counter_table #(
  parameter int PRED_ENTRIES = 16,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_taken,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken
);

  localparam int IDX_W = $clog2(PRED_ENTRIES);

  logic [1:0]       ctr [PRED_ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_pc;

  // word-aligned PCs: the two low bits carry no information
  assign rd_idx    = rd_pc[IDX_W+1:2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign rd_taken  = ctr[rd_idx][1];
  assign unused_pc = ^{rd_pc[ADDR_W-1:IDX_W+2], rd_pc[1:0], upd_pc[ADDR_W-1:IDX_W+2], upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PRED_ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd_en) begin
      if (upd_taken && ctr[upd_idx] != 2'b11)
        ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
      else if (!upd_taken && ctr[upd_idx] != 2'b00)
        ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolution: flag register, condition check, registered redirect and timed flush.
// Optional dynamic prediction is enabled with the BRANCH_PRED_EN macro.
module branch_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int PRED_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic              flags_we,
  input  logic              flagZ_in,
  input  logic              flagS_in,
  input  logic              flagC_in,
`ifdef BRANCH_PRED_EN
  input  logic              pred_in,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
`endif
  output logic              ready_out,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [2:0]        flags_q
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        flags_in;
  logic [2:0]        eff_flags;
  br_dec_t           dec;
  logic              accept;
  logic              do_redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] redir_target;

  assign flags_in  = {flagC_in, flagS_in, flagZ_in};
  // same-cycle flag write is bypassed to the branch being resolved
  assign eff_flags = flags_we ? flags_in : flags_q;
  assign dec       = decode_br(opcode, eff_flags);
  assign accept    = valid_in && ready_out && dec.is_br;
  assign target    = pc + offset;

`ifdef BRANCH_PRED_EN
  bp_counter_table #(
    .PRED_ENTRIES (PRED_ENTRIES),
    .ADDR_W       (ADDR_W)
  ) u_bpt (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (fetch_pc),
    .rd_taken  (pred_taken),
    .upd_en    (accept && !dec.uncond),
    .upd_pc    (pc),
    .upd_taken (dec.taken)
  );

  // only a wrong prediction needs fetch corrected; a not-taken fix resumes at the fall-through
  assign do_redirect  = accept && (dec.taken != pred_in);
  assign redir_target = dec.taken ? target : pc + ADDR_W'(4);
`else
  logic unused_dec;
  assign unused_dec   = dec.uncond;
  assign do_redirect  = accept && dec.taken;
  assign redir_target = target;
`endif

  assign ready_out = (state_q == ST_IDLE);
  assign flush     = (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (do_redirect) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      flags_q        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_valid <= do_redirect;
      if (flags_we)    flags_q     <= flags_in;
      if (do_redirect) redirect_pc <= redir_target;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios then random traffic against a cycle model.
// Build with BRANCH_PRED_EN defined to also exercise the predictor ports.
module tb_branch_unit;

  localparam int AW = 32;
  localparam int FC = 2;
  localparam int PE = 16;

  logic          clk = 1'b0;
  logic          rst, valid_in, flags_we, flagZ_in, flagS_in, flagC_in;
  logic [5:0]    opcode;
  logic [AW-1:0] pc, offset;
  logic          ready_out, redirect_valid, flush;
  logic [AW-1:0] redirect_pc;
  logic [2:0]    flags_q;
`ifdef BRANCH_PRED_EN
  logic          pred_in = 1'b0;
  logic [AW-1:0] fetch_pc = '0;
  logic          pred_taken;
`endif

  int checks = 0;
  int errors = 0;

  // reference state: flags, remaining flush cycles, last redirect, predictor counters
  logic [2:0]    m_flags;
  int            m_busy;
  logic          m_rv;
  logic [AW-1:0] m_rpc;
  int            m_ctr [PE];

  branch_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .PRED_ENTRIES(PE)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .pc(pc), .offset(offset),
    .flags_we(flags_we), .flagZ_in(flagZ_in), .flagS_in(flagS_in), .flagC_in(flagC_in),
`ifdef BRANCH_PRED_EN
    .pred_in(pred_in), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
`endif
    .ready_out(ready_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 1 = taken, 0 = not taken, -1 = not a branch
  function automatic int cond_of(input logic [5:0] op, input logic z, input logic s, input logic c);
    case (op)
      6'd14:   return 1;
      6'd15:   return int'(s);
      6'd16:   return int'(!s && !z);
      6'd17:   return int'(z);
      6'd18:   return int'(!z);
      6'd19:   return int'(c);
      6'd20:   return int'(!c);
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = '0; m_busy = 0; m_rv = 1'b0; m_rpc = '0;
    for (int i = 0; i < PE; i++) m_ctr[i] = 1;
  endtask

  task automatic model_redirect(input logic [AW-1:0] tgt);
    m_rv = 1'b1; m_rpc = tgt; m_busy = FC;
  endtask

  // one clock: drive, check at negedge, advance model, move past the rising edge
  task automatic step(input logic r, input logic v, input logic [5:0] op, input logic [AW-1:0] p,
                      input logic [AW-1:0] o, input logic we, input logic z, input logic s, input logic c);
    logic [2:0] eff;
    int         t;
    bit         acc;
    rst = r; valid_in = v; opcode = op; pc = p; offset = o;
    flags_we = we; flagZ_in = z; flagS_in = s; flagC_in = c;
    @(negedge clk);
    chk("ready_out", ready_out, m_busy == 0);
    chk("flush", flush, m_busy != 0);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("flags_q", flags_q, m_flags);
`ifdef BRANCH_PRED_EN
    chk("pred_taken", pred_taken, m_ctr[(fetch_pc / 4) % PE] >= 2);
`endif
    if (r) begin
      model_reset();
    end else begin
      eff  = we ? {c, s, z} : m_flags;
      t    = cond_of(op, eff[0], eff[1], eff[2]);
      acc  = v && m_busy == 0 && t >= 0;
      m_rv = 1'b0;
      if (m_busy > 0) m_busy--;
`ifdef BRANCH_PRED_EN
      if (acc && (t == 1) != pred_in) model_redirect(t == 1 ? p + o : p + 4);
      if (acc && op != 6'd14) begin
        if (t == 1 && m_ctr[(p / 4) % PE] < 3) m_ctr[(p / 4) % PE]++;
        if (t == 0 && m_ctr[(p / 4) % PE] > 0) m_ctr[(p / 4) % PE]--;
      end
`else
      if (acc && t == 1) model_redirect(p + o);
`endif
      if (we) m_flags = {c, s, z};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 6'd0, '0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; opcode = '0; pc = '0; offset = '0;
    flags_we = 1'b0; flagZ_in = 1'b0; flagS_in = 1'b0; flagC_in = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // reset held two cycles then released
    step(1, 0, 6'd0, '0, '0, 0, 0, 0, 0);
    step(1, 0, 6'd0, '0, '0, 1, 1, 1, 1);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_flush", flush, 1'b0);
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_flags", flags_q, 3'b000);

    // BZ after Z written: one-cycle redirect, flush for two cycles
    step(0, 0, 6'd0, '0, '0, 1, 1, 0, 0);
    step(0, 1, 6'd17, 32'h100, 32'h20, 0, 0, 0, 0);
    chk("bz_rv", redirect_valid, 1'b1);
    chk("bz_rpc", redirect_pc, 32'h120);
    chk("bz_ready", ready_out, 1'b0);
    idle(1);
    chk("bz_rv_pulse", redirect_valid, 1'b0);
    chk("bz_flush2", flush, 1'b1);
    idle(1);
    chk("bz_flush_end", flush, 1'b0);
    chk("bz_ready_back", ready_out, 1'b1);

    // same-cycle flag write bypassed into BMI; BPL with Z set is not taken
    step(0, 1, 6'd15, 32'h40, 32'hFFFF_FFF8, 1, 0, 1, 0);
    chk("bmi_rpc", redirect_pc, 32'h38);
    idle(2);
    step(0, 0, 6'd0, '0, '0, 1, 1, 0, 0);
    step(0, 1, 6'd16, 32'h300, 32'h40, 0, 0, 0, 0);
    chk("bpl_rv", redirect_valid, 1'b0);
    chk("bpl_flush", flush, 1'b0);

    // target wrap-around; a branch offered during flush is dropped
    step(0, 1, 6'd14, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0);
    chk("wrap_rpc", redirect_pc, 32'h10);
    step(0, 1, 6'd14, 32'h500, 32'h4, 0, 0, 0, 0);
    idle(2);
    chk("wrap_no_2nd", redirect_pc, 32'h10);

    // reset on the first flush cycle aborts it
    step(0, 1, 6'd14, 32'h200, 32'h4, 0, 0, 0, 0);
    step(1, 0, 6'd0, '0, '0, 0, 0, 0, 0);
    chk("rstfl_flush", flush, 1'b0);
    chk("rstfl_ready", ready_out, 1'b1);
    idle(2);

`ifdef BRANCH_PRED_EN
    // BNZ trained from weakly-not-taken to strongly-taken
    step(0, 0, 6'd0, '0, '0, 1, 0, 0, 0);
    pred_in = 1'b0;
    step(0, 1, 6'd18, 32'h80, 32'h10, 0, 0, 0, 0);
    chk("bp_mis_rv", redirect_valid, 1'b1);
    chk("bp_mis_rpc", redirect_pc, 32'h90);
    idle(2);
    pred_in = 1'b1;
    step(0, 1, 6'd18, 32'h80, 32'h10, 0, 0, 0, 0);
    step(0, 1, 6'd18, 32'h80, 32'h10, 0, 0, 0, 0);
    chk("bp_hit_rv", redirect_valid, 1'b0);
    chk("bp_hit_flush", flush, 1'b0);
    fetch_pc = 32'h80;
    idle(1);
    chk("bp_pred", pred_taken, 1'b1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  op;
      logic [31:0] off;
      op  = ($urandom % 4 == 0) ? 6'($urandom) : 6'(14 + $urandom % 7);
      off = ($urandom % 2 == 0) ? 32'($signed($urandom % 256) - 128) : $urandom;
`ifdef BRANCH_PRED_EN
      pred_in  = 1'($urandom);
      fetch_pc = {26'($urandom), 4'($urandom), 2'b00};
`endif
      step($urandom % 60 == 0, $urandom % 10 < 7, op, {$urandom} & 32'hFFFF_FFFC, off,
           $urandom % 3 == 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
